// File: rtl/d_responder_pkg.sv
// d_responder_pkg: shared state encodings, CRC16 polynomial
// and CRC status token values for the SD card-side D-line responder.
package d_responder_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_SEND_START = 4'd1,
    S_SEND_DATA  = 4'd2,
    S_SEND_CRC   = 4'd3,
    S_SEND_END   = 4'd4,
    S_WAIT_RCV   = 4'd5,
    S_RCV_DATA   = 4'd6,
    S_RCV_CRC    = 4'd7,
    S_CRC_STATUS = 4'd8,
    S_BUSY       = 4'd9
  } state_t;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] CRC_POLY = 16'h1021;

  localparam logic [2:0] TOK_OK  = 3'b010;
  localparam logic [2:0] TOK_ERR = 3'b101;

endpackage

// File: rtl/d_responder_crc16.sv
// d_responder_crc16: serial CRC16 for one SD data line,
// with an unload mode that shifts the remainder out MSB first.
module d_responder_crc16
  import d_responder_pkg::*;
(
  input  logic iclk,
  input  logic irst,
  input  logic iclr,
  input  logic ishift,
  input  logic iunload,
  input  logic idin,
  output logic omsb
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  // next remainder: clear, absorb one data bit, or shift out
  always_comb begin
    fb    = idin ^ crc_q[15];
    crc_d = crc_q;
    if (iclr) begin
      crc_d = '0;
    end else if (ishift) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0);
    end else if (iunload) begin
      crc_d = {crc_q[14:0], 1'b0};
    end
  end

  // remainder register
  always_ff @(posedge iclk) begin
    if (irst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign omsb = crc_q[15];

endmodule

// File: rtl/d_responder.sv
// d_responder: card-side SD 4-bit data bus responder (block send and
// receive). D_RESPONDER_CRC_TOKEN_EN enables the CRC status token + busy.
module d_responder
  import d_responder_pkg::*;
#(
  parameter int BLOCK_NIBBLES = 1024,
  parameter int ADDR_W        = 10,
  parameter int BUSY_CYCLES   = 8
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic [3:0]        idata_sd,
  output logic [3:0]        odata_sd,
  input  logic              istart_send,
  input  logic              istart_recv,
  output logic [ADDR_W-1:0] oaddr,
  input  logic [3:0]        irdata,
  output logic [3:0]        owdata,
  output logic              owrite_en,
  output logic              ocrc_fail,
  output logic              odone
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DATA_LAST = CW'(BLOCK_NIBBLES - 1);
  localparam logic [CW-1:0] CRC_LAST  = CW'(15);
  localparam logic [CW-1:0] END_CNT   = CW'(16);
  localparam logic [CW-1:0] TOK_LAST  = CW'(4);
  localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]  rx_q;
  logic        fail_q;
  logic        fail_d;

  logic [3:0]  crc_msb;
  logic [3:0]  crc_din;
  logic        crc_clr;
  logic        crc_shift;
  logic        crc_unload;
  logic [2:0]  tok;
  logic        tok_bit;

  // state, phase counter, sticky CRC flag and registered bus input
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
      rx_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      rx_q    <= idata_sd;
    end
  end

  // next state, counter and CRC check result
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    unique case (state_q)
      S_IDLE: begin
        if (istart_send) begin
          state_d = S_SEND_START;
        end else if (istart_recv) begin
          state_d = S_WAIT_RCV;
          fail_d  = 1'b0;
        end
      end
      S_SEND_START: state_d = S_SEND_DATA;
      S_SEND_DATA: begin
        if (cnt_q == DATA_LAST) state_d = S_SEND_CRC;
      end
      S_SEND_CRC: begin
        if (cnt_q == CRC_LAST) state_d = S_SEND_END;
      end
      S_SEND_END: state_d = S_IDLE;
      S_WAIT_RCV: begin
        if (rx_q == 4'h0) state_d = S_RCV_DATA;
      end
      S_RCV_DATA: begin
        if (cnt_q == DATA_LAST) state_d = S_RCV_CRC;
      end
      S_RCV_CRC: begin
        if (cnt_q == END_CNT) begin
          if (rx_q != 4'hF) fail_d = 1'b1;
`ifdef D_RESPONDER_CRC_TOKEN_EN
          state_d = S_CRC_STATUS;
`else
          state_d = S_IDLE;
`endif
        end else if (rx_q != crc_msb) begin
          fail_d = 1'b1;
        end
      end
      S_CRC_STATUS: begin
        if (cnt_q == TOK_LAST) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (cnt_q == BUSY_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = cnt_q + CW'(1);
    if (state_d != state_q ||
        state_q == S_IDLE ||
        state_q == S_WAIT_RCV) begin
      cnt_d = '0;
    end
  end

  // bus, RAM and CRC-engine controls decoded from state and count
  always_comb begin
    tok     = fail_q ? TOK_ERR : TOK_OK;
    tok_bit = 1'b1;
    if (cnt_q == CW'(0)) tok_bit = 1'b0;
    else if (cnt_q == CW'(1)) tok_bit = tok[2];
    else if (cnt_q == CW'(2)) tok_bit = tok[1];
    else if (cnt_q == CW'(3)) tok_bit = tok[0];

    odata_sd  = 4'hF;
    oaddr     = '0;
    owrite_en = 1'b0;
    unique case (state_q)
      S_SEND_START: odata_sd = 4'h0;
      S_SEND_DATA: begin
        odata_sd = irdata;
        oaddr    = cnt_q[ADDR_W-1:0] + ADDR_W'(1);
      end
      S_SEND_CRC:   odata_sd = crc_msb;
      S_RCV_DATA: begin
        oaddr     = cnt_q[ADDR_W-1:0];
        owrite_en = 1'b1;
      end
      S_CRC_STATUS: odata_sd = {3'b111, tok_bit};
      S_BUSY:       odata_sd = 4'hE;
      default:      odata_sd = 4'hF;
    endcase

    crc_clr    = state_q inside {S_IDLE, S_WAIT_RCV, S_SEND_START};
    crc_shift  = state_q inside {S_SEND_DATA, S_RCV_DATA};
    crc_unload = (state_q == S_SEND_CRC) ||
                 (state_q == S_RCV_CRC && cnt_q != END_CNT);
    crc_din    = (state_q == S_SEND_DATA) ? irdata : rx_q;
  end

  assign owdata    = rx_q;
  assign ocrc_fail = fail_q;
  assign odone     = (state_q == S_IDLE);

  for (genvar i = 0; i < 4; i++) begin : g_crc
    d_responder_crc16 u_crc (
      .iclk    (iclk),
      .irst    (irst),
      .iclr    (crc_clr),
      .ishift  (crc_shift),
      .iunload (crc_unload),
      .idin    (crc_din[i]),
      .omsb    (crc_msb[i])
    );
  end

endmodule

// File: tb/tb_d_responder.sv
// tb_d_responder: scoreboard bench for d_responder; expected bus
// nibbles, RAM writes and frame results are queued by the stimulus.
module tb_d_responder;

  localparam int NB = 1024;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic [3:0]  idata_sd = 4'hF;
  logic [3:0]  odata_sd;
  logic        istart_send = 1'b0;
  logic        istart_recv = 1'b0;
  logic [9:0]  oaddr;
  logic [3:0]  irdata;
  logic [3:0]  owdata;
  logic        owrite_en;
  logic        ocrc_fail;
  logic        odone;

  always #5 iclk = ~iclk;

  d_responder dut (
    .iclk        (iclk),
    .irst        (irst),
    .idata_sd    (idata_sd),
    .odata_sd    (odata_sd),
    .istart_send (istart_send),
    .istart_recv (istart_recv),
    .oaddr       (oaddr),
    .irdata      (irdata),
    .owdata      (owdata),
    .owrite_en   (owrite_en),
    .ocrc_fail   (ocrc_fail),
    .odone       (odone)
  );

  logic [3:0] mem [NB];

  always @(posedge iclk) begin
    irdata <= mem[oaddr];
    if (owrite_en) mem[oaddr] <= owdata;
  end

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]  exp_tx [$];
  logic [13:0] exp_wr [$];
  int          exp_len [$];
  logic        exp_fail [$];
  logic [3:0]  blk [NB];

  bit mon_en = 1'b0;
  bit prev_busy = 1'b0;
  int busy_len = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: DUT output with nothing expected at %0t",
             nm, $time);
  endtask

  // reference CRC by augmented division: M(x)*x^16 mod G(x)
  function automatic logic [15:0] gold_crc(input int line);
    logic [15:0] r = 16'h0;
    logic        top;
    logic        b;
    for (int k = 0; k < NB + 16; k++) begin
      b = (k < NB) ? blk[k][line] : 1'b0;
      top = r[15];
      r = {r[14:0], b};
      if (top) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  function automatic logic [3:0] crc_nib(input logic [15:0] c0,
                                         input logic [15:0] c1,
                                         input logic [15:0] c2,
                                         input logic [15:0] c3,
                                         input int j);
    return {c3[15-j], c2[15-j], c1[15-j], c0[15-j]};
  endfunction

  // monitor: compares every busy-cycle nibble, every RAM write,
  // and the frame length / CRC flag when odone returns high
  always @(negedge iclk) begin
    if (mon_en) begin
      if (odone === 1'b0) begin
        busy_len = busy_len + 1;
        if (exp_tx.size() == 0) unexpected("tx_extra");
        else chk("tx_nibble", odata_sd, exp_tx.pop_front());
      end else if (prev_busy) begin
        if (exp_len.size() == 0) begin
          unexpected("frame_extra");
        end else begin
          chk("frame_len", busy_len, exp_len.pop_front());
          chk("crc_fail", ocrc_fail, exp_fail.pop_front());
          chk("idle_bus", odata_sd, 4'hF);
        end
        busy_len = 0;
      end
      prev_busy = (odone === 1'b0);
      if (owrite_en === 1'b1) begin
        if (exp_wr.size() == 0) unexpected("wr_extra");
        else chk("ram_write", {oaddr, owdata}, exp_wr.pop_front());
      end
    end
  end

  task automatic pulse(input logic s, input logic r);
    istart_send = s;
    istart_recv = r;
    @(posedge iclk); #1;
    istart_send = 1'b0;
    istart_recv = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (odone !== 1'b1 && n < budget) begin
      @(posedge iclk); #1;
      n++;
    end
    chk("done_in_time", n < budget, 1);
    @(negedge iclk);
    @(posedge iclk); #1;
  endtask

  task automatic push_send();
    logic [15:0] c0, c1, c2, c3;
    c0 = gold_crc(0);
    c1 = gold_crc(1);
    c2 = gold_crc(2);
    c3 = gold_crc(3);
    exp_tx.push_back(4'h0);
    for (int k = 0; k < NB; k++) exp_tx.push_back(blk[k]);
    for (int j = 0; j < 16; j++)
      exp_tx.push_back(crc_nib(c0, c1, c2, c3, j));
    exp_tx.push_back(4'hF);
    exp_len.push_back(NB + 18);
    exp_fail.push_back(1'b0);
  endtask

  task automatic recv_frame(input int p,
                            input int flip_j,
                            input logic [3:0] endn);
    logic [15:0] c0, c1, c2, c3;
    logic [3:0]  nib;
    logic        bad;
    for (int k = 0; k < NB; k++) blk[k] = 4'(k * p + (k >> 3));
    c0 = gold_crc(0);
    c1 = gold_crc(1);
    c2 = gold_crc(2);
    c3 = gold_crc(3);
    bad = (flip_j >= 0) || (endn != 4'hF);
    for (int k = 0; k < NB; k++) exp_wr.push_back({10'(k), blk[k]});
    repeat (7 + NB + 17) exp_tx.push_back(4'hF);
`ifdef D_RESPONDER_CRC_TOKEN_EN
    if (bad) begin
      exp_tx.push_back(4'hE); exp_tx.push_back(4'hF);
      exp_tx.push_back(4'hE); exp_tx.push_back(4'hF);
      exp_tx.push_back(4'hF);
    end else begin
      exp_tx.push_back(4'hE); exp_tx.push_back(4'hE);
      exp_tx.push_back(4'hF); exp_tx.push_back(4'hE);
      exp_tx.push_back(4'hF);
    end
    repeat (8) exp_tx.push_back(4'hE);
    exp_len.push_back(7 + NB + 17 + 5 + 8);
`else
    exp_len.push_back(7 + NB + 17);
`endif
    exp_fail.push_back(bad);
    pulse(1'b0, 1'b1);
    repeat (5) begin
      idata_sd = 4'hF;
      @(posedge iclk); #1;
    end
    idata_sd = 4'h0;
    @(posedge iclk); #1;
    for (int k = 0; k < NB; k++) begin
      idata_sd = blk[k];
      @(posedge iclk); #1;
    end
    for (int j = 0; j < 16; j++) begin
      nib = crc_nib(c0, c1, c2, c3, j);
      if (j == flip_j) nib[2] = ~nib[2];
      idata_sd = nib;
      @(posedge iclk); #1;
    end
    idata_sd = endn;
    @(posedge iclk); #1;
    idata_sd = 4'hF;
    wait_idle(100);
  endtask

  initial begin
    for (int k = 0; k < NB; k++) mem[k] <= 4'(k);
    irst = 1'b1;
    repeat (3) @(posedge iclk);
    #1;
    chk("rst_odata", odata_sd, 4'hF);
    chk("rst_oaddr", oaddr, 0);
    chk("rst_wen", owrite_en, 0);
    chk("rst_crc_fail", ocrc_fail, 0);
    chk("rst_odone", odone, 1);
    irst = 1'b0;
    @(posedge iclk); #1;
    mon_en = 1'b1;
    for (int k = 0; k < NB; k++) blk[k] = 4'(k);

    // plain block send
    push_send();
    pulse(1'b1, 1'b0);
    wait_idle(1100);

    // both starts together, then a stray pulse mid-frame
    push_send();
    pulse(1'b1, 1'b1);
    repeat (100) begin @(posedge iclk); #1; end
    pulse(1'b1, 1'b1);
    wait_idle(1100);

    // reset while nibble 300 is on the bus
    exp_tx.push_back(4'h0);
    for (int k = 0; k <= 300; k++) exp_tx.push_back(blk[k]);
    exp_len.push_back(302);
    exp_fail.push_back(1'b0);
    pulse(1'b1, 1'b0);
    repeat (301) begin @(posedge iclk); #1; end
    irst = 1'b1;
    @(posedge iclk); #1;
    irst = 1'b0;
    wait_idle(10);

    // clean frame after the abort
    push_send();
    pulse(1'b1, 1'b0);
    wait_idle(1100);

    // receives: good, CRC bit flip on D2, bad end, good again
    recv_frame(7, -1, 4'hF);
    recv_frame(11, 5, 4'hF);
    recv_frame(3, -1, 4'h7);
    recv_frame(13, -1, 4'hF);

    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("end_queue_empty", exp_len.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
